// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM encoding.
package mmio_uart_pkg;

  localparam logic [31:0] TXD_OFFSET    = 32'h0;
  localparam logic [31:0] STATUS_OFFSET = 32'h4;

  localparam int BUSY_BIT   = 0;
  localparam int FULL_BIT   = 1;
  localparam int EMPTY_BIT  = 2;
  localparam int OVF_BIT    = 3;
  localparam int IRQEN_BIT  = 4;
  localparam int DONE_BIT   = 5;
  localparam int COUNT_LSB  = 8;
  localparam int COUNT_MSB  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter; popData always presents
// the oldest entry, and push/pop requests are ignored when full/empty.
module uart_tx_fifo
  import mmio_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign popData = mem[rdPtr];

  // NOTE: storage has no reset; only pointers and count define validity,
  // so a reset here would just cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXD/STATUS decode, baud timing and frame FSM.
// Define MMIO_UART_IRQ_EN to add irq_enable/done bits and the tx_irq output.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        uart_txd,
  output logic        tx_irq
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0]      TXD_ADDR    = BASE_ADDR + TXD_OFFSET;
  localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;
  localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  txState_e         state;
  logic [CNT_W-1:0] baudCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic             bitEnd;

  logic             isTxd, isStatus, pushReq, statusWr;
  logic             fifoPop, fifoFull, fifoEmpty;
  logic [7:0]       fifoData;
  logic [AW:0]      fifoCount;
  logic             overflow;
  logic             irqEn, doneFlag;
  logic [31:0]      statusWord;
  logic             unusedBusBits;

  assign isTxd    = (MemBus_Address[31:2] == TXD_ADDR[31:2]);
  assign isStatus = (MemBus_Address[31:2] == STATUS_ADDR[31:2]);
  assign pushReq  = MemWrite && isTxd;
  assign statusWr = MemWrite && isStatus;
  assign unusedBusBits = ^{MemBus_Address[1:0], MemBus_Write_Data[31:8]};

  assign bitEnd  = (baudCnt == BAUD_LAST);
  // A byte leaves the FIFO only when a new frame begins.
  assign fifoPop = !fifoEmpty && ((state == IDLE) || (state == STOP && bitEnd));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushReq),
    .pushData (MemBus_Write_Data[7:0]),
    .pop      (fifoPop),
    .popData  (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      uart_txd <= 1'b1;
    end else begin
      baudCnt <= (state == IDLE || bitEnd) ? '0 : baudCnt + 1'b1;
      case (state)
        IDLE: begin
          uart_txd <= 1'b1;
          if (fifoPop) begin
            shiftReg <= fifoData;
            uart_txd <= 1'b0;
            state    <= START;
          end
        end
        START: if (bitEnd) begin
          uart_txd <= shiftReg[0];
          shiftReg <= shiftReg >> 1;
          bitIdx   <= '0;
          state    <= DATA;
        end
        DATA: if (bitEnd) begin
          if (bitIdx == 3'd7) begin
            uart_txd <= 1'b1;
            state    <= STOP;
          end else begin
            uart_txd <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= bitIdx + 1'b1;
          end
        end
        STOP: if (bitEnd) begin
          if (fifoPop) begin
            shiftReg <= fifoData;
            uart_txd <= 1'b0;
            state    <= START;
          end else begin
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A dropped push sets overflow; if software clears it in the same cycle the set wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (pushReq && fifoFull) begin
      overflow <= 1'b1;
    end else if (statusWr && MemBus_Write_Data[OVF_BIT]) begin
      overflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_IRQ_EN
  logic stopDone;
  assign stopDone = (state == STOP) && bitEnd && fifoEmpty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irqEn    <= 1'b0;
      doneFlag <= 1'b0;
      tx_irq   <= 1'b0;
    end else begin
      if (statusWr) irqEn <= MemBus_Write_Data[IRQEN_BIT];
      if (stopDone)
        doneFlag <= 1'b1;
      else if (statusWr && MemBus_Write_Data[DONE_BIT])
        doneFlag <= 1'b0;
      tx_irq <= irqEn & doneFlag;
    end
  end
`else
  assign irqEn    = 1'b0;
  assign doneFlag = 1'b0;
  assign tx_irq   = 1'b0;
`endif

  // NOTE: every bit gets a default first so always_comb can never infer a latch.
  always_comb begin
    statusWord                      = '0;
    statusWord[BUSY_BIT]            = (state != IDLE);
    statusWord[FULL_BIT]            = fifoFull;
    statusWord[EMPTY_BIT]           = fifoEmpty;
    statusWord[OVF_BIT]             = overflow;
    statusWord[IRQEN_BIT]           = irqEn;
    statusWord[DONE_BIT]            = doneFlag;
    statusWord[COUNT_MSB:COUNT_LSB] = 8'(fifoCount);
  end

  assign Device_Read_Data = (MemRead && isStatus) ? statusWord : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4): a line monitor
// decodes frames and compares them against a scoreboard filled as bytes are stored.
module tb_mmio_uart_tx;

  localparam int          CPB         = 4;
  localparam int          FRAME       = 10 * CPB;
  localparam logic [31:0] TXD_ADDR    = 32'h4000_0018;
  localparam logic [31:0] STATUS_ADDR = 32'h4000_001C;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] MemBus_Address, MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic        uart_txd;
  logic        tx_irq;

  int          nChecks = 0;
  int          nBad    = 0;
  int          cycle   = 0;
  int          nStarts = 0;
  int          frameStarts [$];
  logic [7:0]  sb [$];

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (TXD_ADDR)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemBus_Address    (MemBus_Address),
    .MemBus_Write_Data (MemBus_Write_Data),
    .Device_Read_Data  (Device_Read_Data),
    .uart_txd          (uart_txd),
    .tx_irq            (tx_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic storeWord(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    #1;
    MemWrite          = 1'b1;
    MemBus_Address    = addr;
    MemBus_Write_Data = data;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic peek(input logic [31:0] addr, input logic rd, output logic [31:0] v);
    MemBus_Address = addr;
    MemRead        = rd;
    #1;
    v       = Device_Read_Data;
    MemRead = 1'b0;
  endtask

  task automatic waitStarts(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && nStarts < n; i++) begin
      @(negedge clk);
      #2;
    end
    check(tag, nStarts, n);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    logic [31:0] st;
    peek(STATUS_ADDR, 1'b1, st);
    for (int i = 0; i < budget && (st[0] || sb.size() != 0); i++) begin
      @(negedge clk);
      #2;
      peek(STATUS_ADDR, 1'b1, st);
    end
    check({tag, "_status"}, st, 32'h4);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  // Line monitor: every sample of every bit period must match the first one.
  initial begin : txMonitor
    logic [9:0] lvl;
    logic [7:0] rxByte;
    logic [7:0] expByte;
    int         glitches;
    bit         abort;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && uart_txd === 1'b0) begin
        frameStarts.push_back(cycle);
        nStarts++;
        lvl      = '0;
        glitches = 0;
        abort    = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < CPB; c++) begin
            if (!abort) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (reset !== 1'b1)      abort = 1'b1;
              else if (c == 0)         lvl[k] = uart_txd;
              else if (uart_txd !== lvl[k]) glitches++;
            end
          end
        end
        if (!abort) begin
          rxByte = lvl[8:1];
          check("frame_start_bit", 32'(lvl[0]), 32'h0);
          check("frame_stop_bit", 32'(lvl[9]), 32'h1);
          check("frame_glitches", glitches, 0);
          check("sb_pending", 32'(sb.size() > 0), 32'h1);
          if (sb.size() > 0) begin
            expByte = sb.pop_front();
            check("frame_data", rxByte, expByte);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] st;
    int          ones;
    int          base;
    int          lows;

    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    MemBus_Address = '0; MemBus_Write_Data = '0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", uart_txd, 1);
    check("rst_irq", tx_irq, 0);
    peek(STATUS_ADDR, 1'b1, st);
    check("rst_status", st, 32'h4);
    @(negedge clk);
    #2;
    reset = 1'b1;

    // 2: single frame 0xA5, busy for exactly one frame
    storeWord(TXD_ADDR, 32'hA5);
    sb.push_back(8'hA5);
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      peek(STATUS_ADDR, 1'b1, st);
      if (st[0]) ones++;
      else if (ones > 0) break;
    end
    check("busy_cycles", ones, FRAME);
    waitIdle("t2", 100);

    // 3: three back-to-back frames, count 2,1,0 as frames start
    base = nStarts;
    storeWord(TXD_ADDR, 32'h11); sb.push_back(8'h11);
    storeWord(TXD_ADDR, 32'h22); sb.push_back(8'h22);
    storeWord(TXD_ADDR, 32'h33); sb.push_back(8'h33);
    waitStarts("t3_start1", base + 1, 20);
    peek(STATUS_ADDR, 1'b1, st);
    check("t3_status_cnt2", st, 32'h0000_0201);
    waitStarts("t3_start2", base + 2, 2 * FRAME);
    peek(STATUS_ADDR, 1'b1, st);
    check("t3_status_cnt1", st, 32'h0000_0101);
    waitStarts("t3_start3", base + 3, 2 * FRAME);
    peek(STATUS_ADDR, 1'b1, st);
    check("t3_status_cnt0", st, 32'h0000_0005);
    if (frameStarts.size() >= base + 3) begin
      check("t3_gap12", frameStarts[base+1] - frameStarts[base], FRAME);
      check("t3_gap23", frameStarts[base+2] - frameStarts[base+1], FRAME);
    end
    waitIdle("t3", 200);

    // 4: overflow while a frame is in flight
    base = nStarts;
    storeWord(TXD_ADDR, 32'hC3); sb.push_back(8'hC3);
    waitStarts("t4_start", base + 1, 20);
    for (int i = 0; i < 5; i++) begin
      storeWord(TXD_ADDR, 32'h60 + i);
      if (i < 4) sb.push_back(8'(8'h60 + i));
    end
    peek(STATUS_ADDR, 1'b1, st);
    check("t4_status_full_ovf", st, 32'h0000_040B);
    peek(STATUS_ADDR, 1'b0, st);
    check("t4_no_read_strobe", st, 32'h0);
    peek(TXD_ADDR, 1'b1, st);
    check("t4_txd_read_zero", st, 32'h0);
    storeWord(STATUS_ADDR, 32'h8);
    peek(STATUS_ADDR, 1'b1, st);
    check("t4_ovf_cleared", st, 32'h0000_0403);
    waitIdle("t4", 6 * FRAME);

    // 6: done interrupt (or its absence in the default build)
`ifdef MMIO_UART_IRQ_EN
    storeWord(STATUS_ADDR, 32'h10);
    peek(STATUS_ADDR, 1'b1, st);
    check("t6_irqen", st, 32'h14);
    base = nStarts;
    storeWord(TXD_ADDR, 32'h7E); sb.push_back(8'h7E);
    waitStarts("t6_start", base + 1, 20);
    repeat (FRAME) @(negedge clk);
    #2;
    check("t6_irq_at_stop_end", tx_irq, 0);
    peek(STATUS_ADDR, 1'b1, st);
    check("t6_status_done", st, 32'h34);
    @(negedge clk);
    #2;
    check("t6_irq_rise", tx_irq, 1);
    storeWord(STATUS_ADDR, 32'h30);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("t6_irq_cleared", tx_irq, 0);
    peek(STATUS_ADDR, 1'b1, st);
    check("t6_status_after_w1c", st, 32'h14);
`else
    storeWord(STATUS_ADDR, 32'h30);
    @(negedge clk);
    #2;
    peek(STATUS_ADDR, 1'b1, st);
    check("t6_irq_bits_absent", st, 32'h4);
    check("t6_irq_tied", tx_irq, 0);
`endif

    // 5: reset in the middle of data bit 3 aborts everything
    base = nStarts;
    storeWord(TXD_ADDR, 32'h3C); sb.push_back(8'h3C);
    storeWord(TXD_ADDR, 32'h5A); sb.push_back(8'h5A);
    waitStarts("t5_start", base + 1, 20);
    repeat (17) @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #2;
    check("t5_txd_after_reset", uart_txd, 1);
    peek(STATUS_ADDR, 1'b1, st);
    check("t5_status_after_reset", st, 32'h4);
    check("t5_irq_after_reset", tx_irq, 0);
    reset = 1'b1;
    sb.delete();
    base = nStarts;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("t5_line_idle", lows, 0);
    check("t5_no_new_frame", nStarts, base);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
